instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req  output  1  instruction-memory read request; held until accepted.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address; equals pc while imem_req=1.
REQ-006 Port: imem_ack  input  1  memory accepts request; imem_rdata valid in the same cycle.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: ins_valid  output  1  instruction on instr/opcode is valid for the datapath.
REQ-009 Port: ins_ready  input  1  datapath retires the current instruction this cycle.
REQ-010 Port: instr  output  32  registered instruction word.
REQ-011 Port: opcode  output  6  instr[31:26]; feeds the main control decoder.
REQ-012 Port: branch  input  1  control-decoder branch output for the current instruction.
REQ-013 Port: zero  input  1  ALU zero flag for the current instruction.
REQ-014 Port: jump  input  1  control-decoder jump output for the current instruction.
REQ-015 Port: pc  output  32  address of the current instruction.
REQ-016 Port: retired  output  32  count of retired instructions.

Function
REQ-017 FSM states SHALL be RST_S, FETCH, HOLD.
REQ-018 RST_S SHALL move to FETCH on the first cycle with reset=0; imem_req SHALL first assert in that FETCH cycle.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc SHALL hold stable until imem_ack=1.
REQ-020 On FETCH with imem_ack=1, instr SHALL load imem_rdata and the FSM SHALL enter HOLD next cycle; fetch latency is 1 cycle after ack.
REQ-021 imem_ack while imem_req=0 SHALL be ignored.
REQ-022 In HOLD, ins_valid=1 and instr/opcode/pc SHALL stay stable until ins_ready=1.
REQ-023 On HOLD with ins_ready=1, the block SHALL compute next_pc, increment retired, load pc with next_pc, and enter FETCH; imem_req SHALL drop for 0 cycles (asserts in the following cycle).
REQ-024 next_pc priority: jump=1 -> {pc4[31:28], instr[25:0], 2'b00}; else branch&zero -> pc4 + (sign-extended instr[15:0] << 2); else pc4, where pc4 = pc + 4.
REQ-025 branch, zero and jump SHALL be sampled only in the HOLD&ins_ready cycle; other cycles are don't-care.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32 (pc=32'hFFFF_FFFC sequential -> 32'h0000_0000).
REQ-027 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 ins_valid SHALL be 0 in RST_S and FETCH; ins_ready outside HOLD SHALL be ignored.

Reset
REQ-029 While reset=1: state=RST_S, pc=RESET_PC, imem_req=0, ins_valid=0, instr=0, retired=0, imem_addr=RESET_PC.
REQ-030 Reset asserted mid-FETCH or mid-HOLD SHALL take effect next edge regardless of imem_ack or ins_ready in that cycle; no retire, no count.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding, opcode field positions (31:26, 25:0, 15:0) and RESET_PC default.
REQ-032 One sub-module, next_pc_calc (combinational next_pc per REQ-024), SHALL be instantiated; all remaining logic lives in instr_fetch.

Verification
REQ-033 Reset release, imem_ack held 1, ins_ready held 1 -> imem_addr sequence 0x0,0x4,0x8; retired 1,2 after 2 retires.
REQ-034 imem_ack delayed 5 cycles -> imem_req/imem_addr=0x0 stable all 5 cycles; ins_valid only after ack+1.
REQ-035 instr=0x1000_FFFF at pc=0x100, branch=1, zero=1 -> next imem_addr=0x100 (0x104 + 0xFFFF_FFFC); zero=0 -> 0x104.
REQ-036 instr=0x0800_0040 at pc=0x1000_0000, jump=1, branch=1, zero=1 -> next imem_addr=0x1000_0100 (jump wins).
REQ-037 reset pulsed in HOLD with ins_ready=1 -> retired stays 0, pc=RESET_PC, imem_req reasserts one cycle after reset drops.
REQ-038 RESET_PC=0xFFFF_FFFC, sequential retire -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch unit:
//     - state_t            : fetch FSM state encoding
//     - *_HI / *_LO        : instruction field positions (opcode, jump index,
//                            branch immediate)
//     - DEFAULT_RESET_PC   : default PC loaded on reset
//     - helper functions   : opcode extraction, jump target, branch offset
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Instruction field positions.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int JIDX_HI   = 25;
  localparam int JIDX_LO   = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  localparam int OPCODE_W = OPCODE_HI - OPCODE_LO + 1;
  localparam int JIDX_W   = JIDX_HI - JIDX_LO + 1;
  localparam int IMM_W    = IMM_HI - IMM_LO + 1;

  // Must be word aligned (bits [1:0] zero).
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] ins);
    return ins[OPCODE_HI:OPCODE_LO];
  endfunction

  // Region-relative jump: keep the top nibble of pc+4, replace the rest with
  // the word index shifted to a byte address.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] ins);
    return {pc4[31:28], ins[JIDX_HI:JIDX_LO], 2'b00};
  endfunction

  // Sign-extended 16-bit word offset converted to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [31:0] ins);
    return {{(32-IMM_W-2){ins[IMM_HI]}}, ins[IMM_HI:IMM_LO], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//   Purely combinational next-PC selection for the retiring instruction.
//   Priority: jump > taken branch (branch & zero) > sequential (pc + 4).
//   All arithmetic is modulo 2^32.
//
//   Ports
//     pc      in  32  address of the current instruction
//     instr   in  32  current instruction word
//     branch  in  1   decoder branch output
//     zero    in  1   ALU zero flag
//     jump    in  1   decoder jump output
//     next_pc out 32  address of the following instruction
// -----------------------------------------------------------------------------
module next_pc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + branch_offset(instr);
  assign j_target  = jump_target(pc4, instr);

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = j_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Single-outstanding instruction fetch unit.  Requests the word at pc from
//   instruction memory, registers it, presents it to the datapath, and on
//   retirement advances pc (sequential / branch / jump) and counts the retire.
//
//   Handshakes (valid/ready semantics):
//     memory side  : imem_req is the valid, imem_ack the ready.  imem_req and
//                    imem_addr stay stable until the cycle imem_ack=1; the data
//                    on imem_rdata is captured in that same cycle.  imem_ack
//                    while imem_req=0 has no effect.
//     datapath side: ins_valid is the valid, ins_ready the ready.  instr,
//                    opcode and pc stay stable until the cycle ins_ready=1,
//                    which is the retire cycle.  ins_ready while ins_valid=0
//                    has no effect.  branch/zero/jump are only looked at in
//                    the retire cycle.
//
//   Ports
//     clk        in  1   clock, rising edge
//     reset      in  1   synchronous, active-high
//     imem_req   out 1   fetch request
//     imem_addr  out 32  fetch address (pc)
//     imem_ack   in  1   memory accepts request, imem_rdata valid
//     imem_rdata in  32  fetched word
//     ins_valid  out 1   instr/opcode/pc valid for the datapath
//     ins_ready  in  1   datapath retires current instruction
//     instr      out 32  registered instruction word
//     opcode     out 6   instr[31:26]
//     branch     in  1   decoder branch
//     zero       in  1   ALU zero flag
//     jump       in  1   decoder jump
//     pc         out 32  address of current instruction
//     retired    out 32  retired instruction count (wraps)
//     fsm_state  out 2   debug view of the FSM state
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  output logic [31:0]         pc,
  output logic [31:0]         retired,
  output state_t              fsm_state
);

  state_t      state;
  state_t      state_next;
  logic        fetch_done;
  logic        retire;
  logic [31:0] next_pc;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .instr   (instr),
    .branch  (branch),
    .zero    (zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_S;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs.
  // Request/valid are additionally masked by reset so nothing is advertised
  // in the cycle reset is applied, even if the state register has not yet
  // been cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ins_valid  = 1'b0;
    fetch_done = 1'b0;
    retire     = 1'b0;
    unique case (state)
      RST_S: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = !reset;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        ins_valid = !reset;
        if (ins_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = RST_S;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.  Reset has priority, so a fetch or retire coinciding
  // with reset is discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= 32'h0000_0000;
      retired <= 32'h0000_0000;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

  // While reset is held the address already shows the reset vector.
  assign imem_addr = reset ? RESET_PC : pc;
  assign opcode    = get_opcode(instr);
  assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch.  Three instances with different reset
//   vectors (0x0, 0x1000_0000, 0xFFFF_FFFC) are driven independently.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int N = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [N];
  logic        imem_req   [N];
  logic [31:0] imem_addr  [N];
  logic        imem_ack   [N];
  logic [31:0] imem_rdata [N];
  logic        ins_valid  [N];
  logic        ins_ready  [N];
  logic [31:0] instr_o    [N];
  logic [5:0]  opcode     [N];
  logic        branch     [N];
  logic        zero       [N];
  logic        jump       [N];
  logic [31:0] pc         [N];
  logic [31:0] retired    [N];
  state_t      fsm_state  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_fetch #(
      .RESET_PC((g == 0) ? 32'h0000_0000 :
                (g == 1) ? 32'h1000_0000 : 32'hFFFF_FFFC)
    ) dut (
      .clk        (clk),
      .reset      (reset[g]),
      .imem_req   (imem_req[g]),
      .imem_addr  (imem_addr[g]),
      .imem_ack   (imem_ack[g]),
      .imem_rdata (imem_rdata[g]),
      .ins_valid  (ins_valid[g]),
      .ins_ready  (ins_ready[g]),
      .instr      (instr_o[g]),
      .opcode     (opcode[g]),
      .branch     (branch[g]),
      .zero       (zero[g]),
      .jump       (jump[g]),
      .pc         (pc[g]),
      .retired    (retired[g]),
      .fsm_state  (fsm_state[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  // Decoder flags are scrambled every cycle: only the retire cycle may use them.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      branch[i] = 1'($urandom_range(0, 1));
      zero[i]   = 1'($urandom_range(0, 1));
      jump[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  // One full instruction on instance k, starting from FETCH at address cur_pc.
  task automatic do_instr(input int k, input logic [31:0] cur_pc, input logic [31:0] ins,
                          input logic b, input logic z, input logic j,
                          input logic [31:0] nxt, input logic [5:0] op, input string nm);
    check({nm, ".req"}, 32'(imem_req[k]), 32'd1);
    check({nm, ".addr"}, imem_addr[k], cur_pc);
    imem_ack[k]   = 1'b1;
    imem_rdata[k] = ins;
    tick();
    imem_ack[k]   = 1'b0;
    imem_rdata[k] = $urandom;
    check({nm, ".valid"}, 32'(ins_valid[k]), 32'd1);
    check({nm, ".instr"}, instr_o[k], ins);
    check({nm, ".opcode"}, 32'(opcode[k]), 32'(op));
    check({nm, ".pc"}, pc[k], cur_pc);
    ins_ready[k] = 1'b1;
    branch[k]    = b;
    zero[k]      = z;
    jump[k]      = j;
    tick();
    ins_ready[k] = 1'b0;
    check({nm, ".valid_drop"}, 32'(ins_valid[k]), 32'd0);
    check({nm, ".next_addr"}, imem_addr[k], nxt);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          k;
    logic [31:0] cur_pc;
    logic [31:0] ins;
    logic        b;
    logic        z;
    logic        j;
    logic [31:0] nxt;
    logic [5:0]  op;
  } vec_t;

  vec_t vt[$];

  initial begin
    int first_req;
    logic [31:0] exp_addr;

    for (int i = 0; i < N; i++) begin
      reset[i]      = 1'b1;
      imem_ack[i]   = 1'b0;
      imem_rdata[i] = 32'h0;
      ins_ready[i]  = 1'b0;
      branch[i]     = 1'b0;
      zero[i]       = 1'b0;
      jump[i]       = 1'b0;
    end

    //           k  pc            instr         b     z     j     next          op
    vt.push_back('{0, 32'h0000_0008, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 6'h02});
    vt.push_back('{0, 32'h0000_0100, 32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 6'h04});
    vt.push_back('{0, 32'h0000_0100, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 6'h04});
    vt.push_back('{0, 32'h0000_0104, 32'h1000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_0114, 6'h04});
    vt.push_back('{0, 32'h0000_0114, 32'h0800_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 6'h02});
    vt.push_back('{0, 32'h0000_0000, 32'h1000_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 6'h04});
    vt.push_back('{0, 32'h0000_0004, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 6'h3F});
    vt.push_back('{0, 32'h0000_0008, 32'h1000_8000, 1'b1, 1'b1, 1'b0, 32'hFFFE_000C, 6'h04});
    vt.push_back('{0, 32'hFFFE_000C, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 6'h02});
    vt.push_back('{0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'h00});
    vt.push_back('{1, 32'h1000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h1000_0100, 6'h02});
    vt.push_back('{2, 32'hFFFF_FFFC, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'h08});

    // --- Reset state ---------------------------------------------------------
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      exp_addr = (i == 0) ? 32'h0000_0000 : (i == 1) ? 32'h1000_0000 : 32'hFFFF_FFFC;
      check($sformatf("rst%0d.req", i), 32'(imem_req[i]), 32'd0);
      check($sformatf("rst%0d.valid", i), 32'(ins_valid[i]), 32'd0);
      check($sformatf("rst%0d.instr", i), instr_o[i], 32'd0);
      check($sformatf("rst%0d.retired", i), retired[i], 32'd0);
      check($sformatf("rst%0d.pc", i), pc[i], exp_addr);
      check($sformatf("rst%0d.addr", i), imem_addr[i], exp_addr);
      check($sformatf("rst%0d.state", i), 32'(fsm_state[i]), 32'(RST_S));
    end

    // --- Back-to-back: ack and ready held high -------------------------------
    exp_q = {32'h0, 32'h4, 32'h8};
    imem_ack[0]   = 1'b1;
    ins_ready[0]  = 1'b1;
    imem_rdata[0] = 32'h0000_0000;
    for (int i = 0; i < N; i++) reset[i] = 1'b0;
    check("rel.req_before_edge", 32'(imem_req[0]), 32'd0);
    first_req = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      branch[0] = 1'b0;
      zero[0]   = 1'b0;
      jump[0]   = 1'b0;
      if (imem_req[0]) begin
        if (first_req < 0) first_req = c;
        check($sformatf("b2b.addr%0d", 3 - exp_q.size()), imem_addr[0], exp_q.pop_front());
        if (exp_q.size() == 0) begin
          imem_ack[0]  = 1'b0;
          ins_ready[0] = 1'b0;
          break;
        end
      end
    end
    check("b2b.first_req_cycle", 32'(first_req), 32'd1);
    check("b2b.timeout_left", 32'(exp_q.size()), 32'd0);
    check("b2b.retired", retired[0], 32'd2);

    // --- Table: branch / jump / sequential -----------------------------------
    for (int v = 0; v < vt.size(); v++) begin
      do_instr(vt[v].k, vt[v].cur_pc, vt[v].ins, vt[v].b, vt[v].z, vt[v].j,
               vt[v].nxt, vt[v].op, $sformatf("vec%0d", v));
    end
    check("tbl.retired0", retired[0], 32'd12);
    check("tbl.retired1", retired[1], 32'd1);
    check("tbl.retired2", retired[2], 32'd1);

    // --- Delayed ack: request stable 5 cycles, stray ins_ready ignored -------
    ins_ready[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("dly%0d.req", c), 32'(imem_req[0]), 32'd1);
      check($sformatf("dly%0d.addr", c), imem_addr[0], 32'h0);
      check($sformatf("dly%0d.valid", c), 32'(ins_valid[0]), 32'd0);
    end
    check("dly.retired", retired[0], 32'd12);
    ins_ready[0]  = 1'b0;
    imem_ack[0]   = 1'b1;
    imem_rdata[0] = 32'hABCD_1234;
    check("dly.valid_at_ack", 32'(ins_valid[0]), 32'd0);
    tick();
    check("dly.valid_after_ack", 32'(ins_valid[0]), 32'd1);
    check("dly.instr", instr_o[0], 32'hABCD_1234);
    // Stray acks in HOLD (no request) must not overwrite instr.
    imem_rdata[0] = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hold%0d.instr", c), instr_o[0], 32'hABCD_1234);
      check($sformatf("hold%0d.pc", c), pc[0], 32'h0);
      check($sformatf("hold%0d.req", c), 32'(imem_req[0]), 32'd0);
    end
    imem_ack[0]  = 1'b0;
    ins_ready[0] = 1'b1;
    branch[0]    = 1'b0;
    jump[0]      = 1'b0;
    tick();
    ins_ready[0] = 1'b0;
    check("dly.next_addr", imem_addr[0], 32'h4);
    check("dly.retired_after", retired[0], 32'd13);

    // --- Reset pulsed in HOLD with ins_ready=1 -------------------------------
    imem_ack[0]   = 1'b1;
    imem_rdata[0] = 32'h0800_0100;
    tick();
    imem_ack[0] = 1'b0;
    check("rsth.valid", 32'(ins_valid[0]), 32'd1);
    reset[0]     = 1'b1;
    ins_ready[0] = 1'b1;
    jump[0]      = 1'b1;
    tick();
    check("rsth.retired", retired[0], 32'd0);
    check("rsth.pc", pc[0], 32'h0);
    check("rsth.req", 32'(imem_req[0]), 32'd0);
    check("rsth.state", 32'(fsm_state[0]), 32'(RST_S));
    reset[0]     = 1'b0;
    ins_ready[0] = 1'b0;
    check("rsth.req_at_release", 32'(imem_req[0]), 32'd0);
    tick();
    check("rsth.req_next", 32'(imem_req[0]), 32'd1);
    check("rsth.addr_next", imem_addr[0], 32'h0);
    check("rsth.retired_next", retired[0], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
